// File: rtl/pc_stack.sv
// pc_stack: program counter with hardware return-address stack for the
// 22-bit instruction core. Drives the program memory address and
// reacts to the bsr/ret flags decoded from the fetched word. The address
// advances sequentially by default, jumps on bsr and pushes the return
// address, and returns on ret by popping that address.
// Optional build macro: PC_STACK_CIRCULAR_EN. When defined, a bsr on a
// full stack overwrites the oldest entry and ovf_err is tied low. When
// undefined, that push is discarded and ovf_err is set and stays set.
module pc_stack #(
  parameter int DEPTH = 8,
  parameter int SPW   = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            HOLD,
  input  logic [21:0]     PR_code,
  input  logic            bsr_det,
  input  logic            ret_det,
  output logic [9:0]      PC_addr,
  output logic [SPW-1:0]  sp_level,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            ovf_err,
  output logic            unf_err
);

  // Write-pointer width; DEPTH is a power of two, so the pointer wraps mod DEPTH
  localparam int PW = SPW - 1;

  logic [9:0]     r_pc;
  logic [9:0]     r_stack [DEPTH];
  logic [PW-1:0]  r_wp;
  logic [SPW-1:0] r_level;
  logic           r_unf;

  logic [9:0]     w_pc_inc;
  logic [PW-1:0]  w_top_idx;
  logic           w_empty;
  logic           w_full;
  logic           w_do_ret;
  logic           w_do_bsr;
  logic           w_unused_opcode;

  // The opcode field is decoded upstream; only the target bits are used here
  assign w_unused_opcode = ^PR_code[21:10];

  assign w_pc_inc  = r_pc + 10'd1;
  assign w_top_idx = r_wp - PW'(1);
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == SPW'(DEPTH));
  // ret has priority; a simultaneous bsr is dropped without flagging
  assign w_do_ret  = ~HOLD & ret_det;
  assign w_do_bsr  = ~HOLD & bsr_det & ~ret_det;

  // Program counter: ret pops (or steps past an empty ret), bsr jumps, else steps
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc <= '0;
    end else if (w_do_ret) begin
      r_pc <= w_empty ? w_pc_inc : r_stack[w_top_idx];
    end else if (w_do_bsr) begin
      r_pc <= PR_code[9:0];
    end else if (!HOLD) begin
      r_pc <= w_pc_inc;
    end
  end

  // Return-address storage, write pointer and level counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= '0;
      end
      r_wp    <= '0;
      r_level <= '0;
    end else if (w_do_ret) begin
      if (!w_empty) begin
        r_wp    <= w_top_idx;
        r_level <= r_level - SPW'(1);
      end
    end else if (w_do_bsr) begin
`ifdef PC_STACK_CIRCULAR_EN
      // When full, the slot at the write pointer holds the oldest entry
      r_stack[r_wp] <= w_pc_inc;
      r_wp          <= r_wp + PW'(1);
      if (!w_full) begin
        r_level <= r_level + SPW'(1);
      end
`else
      if (!w_full) begin
        r_stack[r_wp] <= w_pc_inc;
        r_wp          <= r_wp + PW'(1);
        r_level       <= r_level + SPW'(1);
      end
`endif
    end
  end

  // Sticky underflow flag: ret seen while the stack is empty
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_unf <= 1'b0;
    end else if (w_do_ret && w_empty) begin
      r_unf <= 1'b1;
    end
  end

`ifdef PC_STACK_CIRCULAR_EN
  assign ovf_err = 1'b0;
`else
  logic r_ovf;

  // Sticky overflow flag: bsr seen while the stack is full
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ovf <= 1'b0;
    end else if (w_do_bsr && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_err = r_ovf;
`endif

  assign PC_addr     = r_pc;
  assign sp_level    = r_level;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign unf_err     = r_unf;

endmodule
